// File: rtl/ps2_rx_framer_if.sv
// ---------------------------------------------------------------------------
// ps2_rx_framer_if
// Read-side bundle of the PS/2 frame receiver. The receiver produces words
// into its output FIFO and the scan-code decoder pulls them out with a
// show-ahead read handshake.
//
// Signals:
//   rd_en       consumer -> receiver  pop request (ignored when empty)
//   rd_data     receiver -> consumer  head of FIFO, zero when empty
//   rd_valid    receiver -> consumer  FIFO not empty
//   fifo_count  receiver -> consumer  number of stored words
//
// Modports:
//   master  the receiver (drives data/valid/count)
//   slave   the consumer (drives rd_en)
// ---------------------------------------------------------------------------
interface ps2_rx_framer_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);

   localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

   logic                 rd_en;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_valid;
   logic [COUNT_W-1:0]   fifo_count;

   modport master (
      input  rd_en,
      output rd_data,
      output rd_valid,
      output fifo_count
   );

   modport slave (
      output rd_en,
      input  rd_data,
      input  rd_valid,
      input  fifo_count
   );

endinterface

// File: rtl/ps2_rx_framer.sv
// ---------------------------------------------------------------------------
// ps2_rx_framer
// PS/2 device-to-host frame receiver. Takes the synchronised PS/2 data line
// plus a one-cycle sample pulse from the clock edge detector, checks start,
// optional parity and stop bits, recovers from stalled frames with an
// inter-edge timeout and buffers good words in a small show-ahead FIFO.
//
// Ports:
//   clk              system clock
//   rst              synchronous, active-high reset
//   enable_i         receiver enable; low forces the FSM back to IDLE
//   ps2_clk_edge_i   one-cycle pulse marking a PS/2 data sample point
//   ps2_data_i       synchronised PS/2 data line
//   rd_if            FIFO read handshake (master side)
//   busy_o           FSM is not IDLE
//   parity_err_strb_o  one-cycle pulse, parity mismatch
//   frame_err_strb_o   one-cycle pulse, bad start or stop bit
//   timeout_strb_o     one-cycle pulse, inter-edge timeout
//   overflow_strb_o    one-cycle pulse, good word dropped because FIFO full
// ---------------------------------------------------------------------------
module ps2_rx_framer #(
   parameter int DATA_BITS      = 8,
   parameter int PARITY_MODE    = 1,
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable_i,
   input  logic            ps2_clk_edge_i,
   input  logic            ps2_data_i,
   ps2_rx_framer_if.master rd_if,
   output logic            busy_o,
   output logic            parity_err_strb_o,
   output logic            frame_err_strb_o,
   output logic            timeout_strb_o,
   output logic            overflow_strb_o
);

   localparam int BIT_W   = $clog2(DATA_BITS);
   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_BITS - 1);
   localparam logic [TMO_W-1:0]   LAST_TMO = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state_q, state_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 enable_q;

   logic                 par_err_q, par_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 tmo_strb_q, tmo_strb_d;
   logic                 overflow_q, overflow_d;

   logic                 push_req;
   logic                 parity_calc;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 pop;
   logic                 push;
   logic                 full;

   // XOR over every data bit plus the parity bit currently on the line;
   // odd parity wants this to be 1, even parity wants 0.
   assign parity_calc = (^shift_q) ^ ps2_data_i;

   // Frame FSM and timeout counter, next-state side. Normal bit handling is
   // done first; an enable drop or an expired timeout then overrides it,
   // which keeps the strobes mutually exclusive by construction.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_bad_d   = par_bad_q;
      tmo_d       = tmo_q;
      push_req    = 1'b0;
      par_err_d   = 1'b0;
      frame_err_d = 1'b0;
      tmo_strb_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable_i) begin
               if (ps2_clk_edge_i) begin
                  if (!ps2_data_i) begin
                     state_d   = DATA;
                     bit_cnt_d = '0;
                     par_bad_d = 1'b0;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end else if (!enable_q) begin
                  state_d = START;
               end
            end
         end

         START: begin
            if (ps2_clk_edge_i) begin
               if (!ps2_data_i) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
                  par_bad_d = 1'b0;
               end else begin
                  state_d     = IDLE;
                  frame_err_d = 1'b1;
               end
            end
         end

         DATA: begin
            if (ps2_clk_edge_i) begin
               shift_d = {ps2_data_i, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_MODE == 0) ? STOP : PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end

         PARITY: begin
            if (ps2_clk_edge_i) begin
               par_bad_d = (PARITY_MODE == 1) ? ~parity_calc : parity_calc;
               state_d   = STOP;
            end
         end

         STOP: begin
            if (ps2_clk_edge_i) begin
               state_d = IDLE;
               if (!ps2_data_i) begin
                  frame_err_d = 1'b1;
               end else if (par_bad_q) begin
                  par_err_d = 1'b1;
               end else begin
                  push_req = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_q != IDLE) begin
         if (!enable_i) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            push_req    = 1'b0;
            par_err_d   = 1'b0;
            frame_err_d = 1'b0;
         end else if (!ps2_clk_edge_i && (tmo_q == LAST_TMO)) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            tmo_strb_d = 1'b1;
         end
      end

      // The counter only runs while a frame is in flight; clearing on the
      // transition out of IDLE as well keeps the first START/DATA cycle at 0.
      if ((state_q == IDLE) || (state_d == IDLE) || ps2_clk_edge_i) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   // Frame FSM state register, including the registered enable used to
   // detect an enable rise that arrives between PS/2 edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         tmo_q     <= '0;
         enable_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         tmo_q     <= tmo_d;
         enable_q  <= enable_i;
      end
   end

   // FIFO next-state. A push into a full FIFO succeeds only if a pop frees
   // a slot in the same cycle; otherwise the word is dropped and flagged.
   always_comb begin
      pop        = rd_if.rd_en && (count_q != '0);
      full       = (count_q == FULL_CNT);
      push       = push_req && (!full || pop);
      overflow_d = push_req && full && !pop;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + COUNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - COUNT_W'(1);
      end
   end

   // FIFO pointers and occupancy. Pointers wrap naturally because the depth
   // is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage. It needs no reset because rd_data is masked to zero
   // whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   // Error strobes are registered so they leave the block glitch-free and
   // line up with the cycle in which a pushed word becomes visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         tmo_strb_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
         tmo_strb_q  <= tmo_strb_d;
         overflow_q  <= overflow_d;
      end
   end

   assign rd_if.rd_valid   = (count_q != '0);
   assign rd_if.rd_data    = rd_if.rd_valid ? mem_q[rd_ptr_q] : '0;
   assign rd_if.fifo_count = count_q;

   assign busy_o            = (state_q != IDLE);
   assign parity_err_strb_o = par_err_q;
   assign frame_err_strb_o  = frame_err_q;
   assign timeout_strb_o    = tmo_strb_q;
   assign overflow_strb_o   = overflow_q;

endmodule
